// File: rtl/core_types.sv
// Shared types for the data-side request path: MEM-stage request struct,
// request-controller state encoding and bus size codes.
package core_types;

    localparam logic [1:0] DATA_SIZE_B = 2'd0;
    localparam logic [1:0] DATA_SIZE_H = 2'd1;
    localparam logic [1:0] DATA_SIZE_W = 2'd2;

    typedef struct packed {
        logic        ce;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_cache_struct;

    typedef enum logic [2:0] {
        DRQ_IDLE,
        DRQ_REQ,
        DRQ_WAIT,
        DRQ_DONE,
        DRQ_DRAIN
    } data_req_state_t;

endpackage

// File: rtl/sel_to_size.sv
// Byte-select to bus-size decode; sel=0 marks a request that needs no bus
// access (failed SC, misaligned halfword store).
module sel_to_size
    import core_types::*;
(
    input  logic [3:0] sel_i,
    output logic [1:0] size_o,
    output logic       noop_o
);

    always_comb begin
        noop_o = (sel_i == 4'b0000);
        unique case (sel_i)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size_o = DATA_SIZE_B;
            4'b0011, 4'b1100:                   size_o = DATA_SIZE_H;
            default:                            size_o = DATA_SIZE_W;
        endcase
    end

endmodule

// File: rtl/data_req_ctrl.sv
// MEM-stage to SRAM-like data bus request controller: one bus transaction per
// request, result held until advance, flushed transactions drained.
// Optional performance counters: define DATA_REQ_PERF_EN.
module data_req_ctrl
    import core_types::*;
(
    input  logic            clk,
    input  logic            rst,
    input  mem_cache_struct req_i,
    input  logic            advance_i,
    input  logic            flush_i,
    output logic            addr_ok_o,
    output logic            data_ok_o,
    output logic [31:0]     rdata_o,
    output logic            data_req_o,
    output logic            data_wr_o,
    output logic [1:0]      data_size_o,
    output logic [3:0]      data_wstrb_o,
    output logic [31:0]     data_addr_o,
    output logic [31:0]     data_wdata_o,
    input  logic            data_addr_ok_i,
    input  logic            data_data_ok_i,
    input  logic [31:0]     data_rdata_i,
    output logic [31:0]     perf_ld_cnt_o,
    output logic [31:0]     perf_st_cnt_o,
    output logic [31:0]     perf_wait_cnt_o
);

    data_req_state_t state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  sel_q, sel_d;
    logic [1:0]  size_q, size_d;
    logic        we_q, we_d;

    logic [1:0]  req_size;
    logic        req_noop;

    sel_to_size u_sel_to_size (
        .sel_i  (req_i.sel),
        .size_o (req_size),
        .noop_o (req_noop)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        sel_d   = sel_q;
        size_d  = size_q;
        we_d    = we_q;
        unique case (state_q)
            DRQ_IDLE: begin
                if (req_i.ce && !req_noop && !flush_i) begin
                    addr_d  = req_i.addr;
                    wdata_d = req_i.data;
                    sel_d   = req_i.sel;
                    we_d    = req_i.we;
                    size_d  = req_size;
                    state_d = DRQ_REQ;
                end
            end
            DRQ_REQ: begin
                // An accepted request is in flight even if flushed; it must be drained.
                if (data_addr_ok_i) state_d = flush_i ? DRQ_DRAIN : DRQ_WAIT;
                else if (flush_i)   state_d = DRQ_IDLE;
            end
            DRQ_WAIT: begin
                if (data_data_ok_i) begin
                    if (flush_i) begin
                        state_d = DRQ_IDLE;
                    end else begin
                        state_d = DRQ_DONE;
                        if (!we_q) rdata_d = data_rdata_i;
                    end
                end else if (flush_i) begin
                    state_d = DRQ_DRAIN;
                end
            end
            DRQ_DONE: begin
                if (advance_i || flush_i) state_d = DRQ_IDLE;
            end
            DRQ_DRAIN: begin
                if (data_data_ok_i) state_d = DRQ_IDLE;
            end
            default: state_d = DRQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DRQ_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            sel_q   <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            sel_q   <= sel_d;
            size_q  <= size_d;
            we_q    <= we_d;
        end
    end

    // Bus side is decoded from registers only.
    assign data_req_o   = (state_q == DRQ_REQ);
    assign data_wr_o    = we_q;
    assign data_size_o  = size_q;
    assign data_wstrb_o = we_q ? sel_q : 4'b0000;
    assign data_addr_o  = addr_q;
    assign data_wdata_o = wdata_q;

    assign addr_ok_o = (state_q == DRQ_REQ) && data_addr_ok_i;
    assign data_ok_o = (state_q == DRQ_DONE) ||
                       ((state_q == DRQ_IDLE) && (!req_i.ce || req_noop));
    assign rdata_o   = (state_q == DRQ_DONE) ? rdata_q : 32'd0;

`ifdef DATA_REQ_PERF_EN
    logic [31:0] perf_ld_q, perf_ld_d;
    logic [31:0] perf_st_q, perf_st_d;
    logic [31:0] perf_wait_q, perf_wait_d;
    logic        enter_done;

    always_comb begin
        enter_done  = (state_d == DRQ_DONE) && (state_q != DRQ_DONE);
        perf_ld_d   = perf_ld_q;
        perf_st_d   = perf_st_q;
        perf_wait_d = perf_wait_q;
        if (enter_done && !we_q) perf_ld_d = perf_ld_q + 32'd1;
        if (enter_done && we_q)  perf_st_d = perf_st_q + 32'd1;
        if (state_q == DRQ_REQ || state_q == DRQ_WAIT) perf_wait_d = perf_wait_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ld_q   <= '0;
            perf_st_q   <= '0;
            perf_wait_q <= '0;
        end else begin
            perf_ld_q   <= perf_ld_d;
            perf_st_q   <= perf_st_d;
            perf_wait_q <= perf_wait_d;
        end
    end

    assign perf_ld_cnt_o   = perf_ld_q;
    assign perf_st_cnt_o   = perf_st_q;
    assign perf_wait_cnt_o = perf_wait_q;
`else
    assign perf_ld_cnt_o   = 32'd0;
    assign perf_st_cnt_o   = 32'd0;
    assign perf_wait_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_data_req_ctrl.sv
// Directed bench for data_req_ctrl: latency, store fields, DONE hold, drain,
// no-op requests, flush corner cases and performance counters.
`timescale 1ns/1ps
module tb_data_req_ctrl;
    import core_types::*;

    logic            clk = 1'b0;
    logic            rst;
    mem_cache_struct req;
    logic            advance, flush;
    logic            addr_ok, data_ok;
    logic [31:0]     rdata;
    logic            bus_req, bus_wr;
    logic [1:0]      bus_size;
    logic [3:0]      bus_wstrb;
    logic [31:0]     bus_addr, bus_wdata;
    logic            bus_addr_ok, bus_data_ok;
    logic [31:0]     bus_rdata;
    logic [31:0]     perf_ld, perf_st, perf_wait;

    int errs = 0;
    int checks = 0;
    int hs_cnt = 0;

    always #5 clk = ~clk;

    data_req_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .req_i           (req),
        .advance_i       (advance),
        .flush_i         (flush),
        .addr_ok_o       (addr_ok),
        .data_ok_o       (data_ok),
        .rdata_o         (rdata),
        .data_req_o      (bus_req),
        .data_wr_o       (bus_wr),
        .data_size_o     (bus_size),
        .data_wstrb_o    (bus_wstrb),
        .data_addr_o     (bus_addr),
        .data_wdata_o    (bus_wdata),
        .data_addr_ok_i  (bus_addr_ok),
        .data_data_ok_i  (bus_data_ok),
        .data_rdata_i    (bus_rdata),
        .perf_ld_cnt_o   (perf_ld),
        .perf_st_cnt_o   (perf_st),
        .perf_wait_cnt_o (perf_wait)
    );

    always @(posedge clk) if (!rst && bus_req && bus_addr_ok) hs_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then changed 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic we, input logic [3:0] sel,
                           input logic [31:0] addr, input logic [31:0] wd);
        req.ce = 1'b1; req.we = we; req.sel = sel; req.addr = addr; req.data = wd;
    endtask

    // Runs a request from IDLE to DONE and stops in DONE (no advance).
    task automatic do_txn(input string tag, input logic we, input logic [3:0] sel,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input logic [1:0] exp_size,
                          input int req_wait, input int resp_wait);
        set_req(we, sel, addr, wd);
        #1;
        chk({tag, ".idle_dok"}, 32'(data_ok), 32'd0);
        chk({tag, ".idle_req"}, 32'(bus_req), 32'd0);
        tick();
        for (int i = 0; i < req_wait; i++) begin
            #1 chk({tag, ".reqwait_req"}, 32'(bus_req), 32'd1);
            tick();
        end
        chk({tag, ".req"}, 32'(bus_req), 32'd1);
        chk({tag, ".addr"}, bus_addr, addr);
        chk({tag, ".size"}, 32'(bus_size), 32'(exp_size));
        chk({tag, ".wr"}, 32'(bus_wr), 32'(we));
        chk({tag, ".wstrb"}, 32'(bus_wstrb), we ? 32'(sel) : 32'd0);
        if (we) chk({tag, ".wdata"}, bus_wdata, wd);
        bus_addr_ok = 1'b1;
        #1 chk({tag, ".addr_ok"}, 32'(addr_ok), 32'd1);
        tick();
        bus_addr_ok = 1'b0;
        for (int i = 0; i < resp_wait; i++) begin
            #1 chk({tag, ".wait_req"}, 32'(bus_req), 32'd0);
            chk({tag, ".wait_dok"}, 32'(data_ok), 32'd0);
            tick();
        end
        bus_data_ok = 1'b1;
        bus_rdata = rd;
        #1 chk({tag, ".resp_dok"}, 32'(data_ok), 32'd0);
        tick();
        bus_data_ok = 1'b0;
        bus_rdata = 32'h0BAD_F00D;
        #1 chk({tag, ".done_dok"}, 32'(data_ok), 32'd1);
        if (!we) chk({tag, ".rdata"}, rdata, rd);
    endtask

    task automatic leave_done();
        advance = 1'b1;
        req.ce = 1'b0;
        tick();
        advance = 1'b0;
    endtask

    initial begin
        int hs0;
        rst = 1'b1; advance = 1'b0; flush = 1'b0;
        req = '0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst.req", 32'(bus_req), 32'd0);
        chk("rst.rdata", rdata, 32'd0);
        chk("rst.addr", bus_addr, 32'd0);
        chk("rst.perf_ld", perf_ld, 32'd0);
        chk("rst.perf_wait", perf_wait, 32'd0);
        tick();

        // LD.W, zero-wait bus: DONE in cycle 3, one handshake
        hs0 = hs_cnt;
        do_txn("ldw", 1'b0, 4'b1111, 32'h1C00_0010, 32'd0, 32'hDEAD_BEEF, DATA_SIZE_W, 0, 0);
        chk("ldw.handshakes", 32'(hs_cnt - hs0), 32'd1);
        leave_done();
        #1 chk("ldw.after_rdata", rdata, 32'd0);

        // ST.B with one-cycle addr_ok delay and one-cycle response delay
        do_txn("stb", 1'b1, 4'b1000, 32'h1C00_0003, 32'h5A5A_5A5A, 32'd0, DATA_SIZE_B, 1, 1);
        leave_done();

        // LD.H then LD.B held in DONE for 5 stalled cycles
        do_txn("ldh", 1'b0, 4'b1100, 32'h1C00_0022, 32'd0, 32'h1234_8765, DATA_SIZE_H, 0, 0);
        leave_done();
        hs0 = hs_cnt;
        do_txn("ldb", 1'b0, 4'b0010, 32'h1C00_0041, 32'd0, 32'h0000_7700, DATA_SIZE_B, 0, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("hold.dok", 32'(data_ok), 32'd1);
            chk("hold.req", 32'(bus_req), 32'd0);
            chk("hold.rdata", rdata, 32'h0000_7700);
            tick();
        end
        chk("hold.handshakes", 32'(hs_cnt - hs0), 32'd1);
        leave_done();

        // Flush in WAIT, response 4 cycles later, new load waiting on req_i
        set_req(1'b0, 4'b1111, 32'h1C00_0100, 32'd0);
        tick();
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_req(1'b0, 4'b1111, 32'h1C00_0200, 32'd0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("drain.dok", 32'(data_ok), 32'd0);
            chk("drain.req", 32'(bus_req), 32'd0);
            tick();
        end
        bus_data_ok = 1'b1;
        bus_rdata = 32'hFFFF_0000;
        #1 chk("drain.last_dok", 32'(data_ok), 32'd0);
        tick();
        bus_data_ok = 1'b0;
        #1 chk("drain.idle_req", 32'(bus_req), 32'd0);
        chk("drain.idle_rdata", rdata, 32'd0);
        tick();
        chk("drain.reissue_req", 32'(bus_req), 32'd1);
        chk("drain.reissue_addr", bus_addr, 32'h1C00_0200);
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b1;
        bus_rdata = 32'hCAFE_0001;
        tick();
        bus_data_ok = 1'b0;
        #1 chk("drain.new_rdata", rdata, 32'hCAFE_0001);
        leave_done();

        // Failed SC (ce=0) and sel=0 no-op: data_ok same cycle, no bus request
        req = '0;
        req.sel = 4'b1111;
        #1 chk("sc.dok", 32'(data_ok), 32'd1);
        tick();
        chk("sc.req", 32'(bus_req), 32'd0);
        set_req(1'b1, 4'b0000, 32'h1C00_0301, 32'h1111_2222);
        #1 chk("sel0.dok", 32'(data_ok), 32'd1);
        tick();
        chk("sel0.req", 32'(bus_req), 32'd0);

        // data_ok together with flush in WAIT goes straight to IDLE
        set_req(1'b0, 4'b1111, 32'h1C00_0400, 32'd0);
        tick();
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b1;
        flush = 1'b1;
        set_req(1'b0, 4'b0001, 32'h1C00_0500, 32'd0);
        tick();
        bus_data_ok = 1'b0;
        flush = 1'b0;
        #1 chk("wflush.dok", 32'(data_ok), 32'd0);
        tick();
        chk("wflush.reissue_req", 32'(bus_req), 32'd1);
        chk("wflush.reissue_addr", bus_addr, 32'h1C00_0500);

        // Flush in REQ without addr_ok withdraws the request
        flush = 1'b1;
        req.ce = 1'b0;
        tick();
        flush = 1'b0;
        #1 chk("rflush.req", 32'(bus_req), 32'd0);
        chk("rflush.dok", 32'(data_ok), 32'd1);
        tick();

        // Counters: 3 loads + 2 stores, each REQ 1 cycle + WAIT 2 cycles
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do_txn("perf", (i % 2) == 1, 4'b1111, 32'h1C00_1000 + 32'(i * 4),
                   32'hA5A5_0000 + 32'(i), 32'h0000_1000 + 32'(i), DATA_SIZE_W, 0, 1);
            leave_done();
        end
        #1;
`ifdef DATA_REQ_PERF_EN
        chk("perf.ld", perf_ld, 32'd3);
        chk("perf.st", perf_st, 32'd2);
        chk("perf.wait", perf_wait, 32'd15);
`else
        chk("perf.ld_off", perf_ld, 32'd0);
        chk("perf.st_off", perf_st, 32'd0);
        chk("perf.wait_off", perf_wait, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
